mem_initiator: RTL and testbench

MEM_INITIATOR -- requirements
Module: mem_initiator

---
 rtl/mem_initiator.sv | 181 ++++++++++++++++++
 tb/tb_mem_initiator.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_initiator.sv
// mem_initiator: 2-entry request FIFO feeding a single-outstanding memory access FSM.
// Optional stall timeout enabled by defining MEM_INIT_TIMEOUT_EN.
`default_nettype none

module mem_initiator #(
   parameter int BIT_W   = 32,
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 64
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic              i_req_wen,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic [BIT_W-1:0]  i_req_wdata,
   output logic              o_rsp_valid,
   output logic [BIT_W-1:0]  o_rsp_rdata,
   output logic              o_rsp_err,
   output logic              o_mem_cen,
   output logic              o_mem_wen,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [BIT_W-1:0]  o_mem_wdata,
   input  logic [BIT_W-1:0]  i_mem_rdata,
   input  logic              i_mem_stall,
   output logic              o_err
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      RECOVER = 2'd2
   } state_t;

   state_t                  state_q, state_d;

   logic [1:0]              fifo_wen_q;
   logic [1:0][ADDR_W-1:0]  fifo_addr_q;
   logic [1:0][BIT_W-1:0]   fifo_wdata_q;
   logic                    rd_ptr_q, wr_ptr_q;
   logic [1:0]              count_q;

   logic                    first_q;
   logic                    rsp_valid_q;
   logic [BIT_W-1:0]        rsp_rdata_q;

   logic                    push, pop;
   logic                    complete, timeout;
   logic                    tmo_hit;
   logic                    head_wen;
   logic [ADDR_W-1:0]       head_addr;
   logic [BIT_W-1:0]        head_wdata;

   assign head_wen   = fifo_wen_q[rd_ptr_q];
   assign head_addr  = fifo_addr_q[rd_ptr_q];
   assign head_wdata = fifo_wdata_q[rd_ptr_q];

   // A full FIFO still accepts on the edge that retires the head.
   assign o_req_ready = (count_q != 2'd2) || pop;
   assign push        = i_req_valid && o_req_ready;
   assign pop         = complete || timeout;

   always_ff @(posedge i_clk) begin
      if (push) begin
         fifo_wen_q[wr_ptr_q]   <= i_req_wen;
         fifo_addr_q[wr_ptr_q]  <= i_req_addr;
         fifo_wdata_q[wr_ptr_q] <= i_req_wdata;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push) wr_ptr_q <= ~wr_ptr_q;
         if (pop)  rd_ptr_q <= ~rd_ptr_q;
         case ({push, pop})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_comb begin
      state_d     = state_q;
      complete    = 1'b0;
      timeout     = 1'b0;
      o_mem_cen   = 1'b0;
      o_mem_wen   = 1'b0;
      o_mem_addr  = '0;
      o_mem_wdata = '0;
      case (state_q)
         IDLE: begin
            if (count_q != 2'd0) state_d = ACCESS;
         end
         ACCESS: begin
            o_mem_cen   = 1'b1;
            o_mem_wen   = head_wen;
            o_mem_addr  = head_addr;
            o_mem_wdata = head_wdata;
            // The first access cycle never completes, whatever the stall input says.
            if (!first_q && !i_mem_stall) begin
               complete = 1'b1;
               state_d  = RECOVER;
            end else if (tmo_hit) begin
               timeout = 1'b1;
               state_d = RECOVER;
            end
         end
         RECOVER: begin
            state_d = (count_q != 2'd0) ? ACCESS : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q     <= IDLE;
         first_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         first_q     <= (state_d == ACCESS) && (state_q != ACCESS);
         rsp_valid_q <= pop;
         if (complete) begin
            rsp_rdata_q <= head_wen ? '0 : i_mem_rdata;
         end else if (timeout) begin
            rsp_rdata_q <= '0;
         end
      end
   end

   assign o_rsp_valid = rsp_valid_q;
   assign o_rsp_rdata = rsp_rdata_q;

`ifdef MEM_INIT_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [CNT_W-1:0] tmo_cnt_q;
   logic             rsp_err_q;
   logic             err_q;

   assign tmo_hit = (tmo_cnt_q == CNT_W'(TIMEOUT - 1));

   // Held at zero outside ACCESS, so every access starts counting from 0.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         tmo_cnt_q <= '0;
         rsp_err_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         if (state_q != ACCESS) begin
            tmo_cnt_q <= '0;
         end else if (!tmo_hit) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
         end
         if (complete) begin
            rsp_err_q <= 1'b0;
         end else if (timeout) begin
            rsp_err_q <= 1'b1;
            err_q     <= 1'b1;
         end
      end
   end

   assign o_rsp_err = rsp_err_q;
   assign o_err     = err_q;
`else
   assign tmo_hit   = 1'b0;
   assign o_rsp_err = 1'b0;
   assign o_err     = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_initiator.sv
// Scoreboard testbench for mem_initiator: directed requests against a stalling memory model.
`default_nettype none

module tb_mem_initiator;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_wen = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        mem_cen;
   logic        mem_wen;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        mem_stall = 1'b0;
   logic        err;

   mem_initiator #(.BIT_W(32), .ADDR_W(32), .TIMEOUT(8)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_req_valid (req_valid),
      .o_req_ready (req_ready),
      .i_req_wen   (req_wen),
      .i_req_addr  (req_addr),
      .i_req_wdata (req_wdata),
      .o_rsp_valid (rsp_valid),
      .o_rsp_rdata (rsp_rdata),
      .o_rsp_err   (rsp_err),
      .o_mem_cen   (mem_cen),
      .o_mem_wen   (mem_wen),
      .o_mem_addr  (mem_addr),
      .o_mem_wdata (mem_wdata),
      .i_mem_rdata (mem_rdata),
      .i_mem_stall (mem_stall),
      .o_err       (err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } rsp_t;

   rsp_t exp_q[$];
   int   runs[$];
   int   gaps[$];
   int   rsp_cyc[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   stall_n = 0;
   int   acc_cyc = 0;
   int   run_len = 0;
   int   zeros = 0;
   logic prev_cen = 1'b0;
   logic prev_valid = 1'b0;
   logic        stab_en = 1'b0;
   logic        stab_wen = 1'b0;
   logic [31:0] stab_addr = '0;
   logic [31:0] stab_wdata = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_val(input logic [31:0] a);
      if (a == 32'h0001_0010) return 32'hDEAD_BEEF;
      return a ^ 32'h1234_5678;
   endfunction

   // Memory model: stalls the first stall_n cycles of every access.
   always @(negedge clk) begin
      if (mem_cen) acc_cyc = acc_cyc + 1;
      else         acc_cyc = 0;
      mem_stall = (acc_cyc != 0) && (acc_cyc <= stall_n);
      mem_rdata = (mem_cen && !mem_stall) ? mem_val(mem_addr) : 32'h0;
   end

   // Monitor: scoreboard pop, access/gap lengths, idle-output and stability checks.
   always @(negedge clk) begin
      rsp_t e;
      if (rst_n) begin
         if (rsp_valid) begin
            chk("rsp_single_cycle", {95'd0, prev_valid}, 96'd0);
            rsp_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_rsp: got rdata %0h err %0b, required no response", rsp_rdata, rsp_err);
            end else begin
               e = exp_q.pop_front();
               chk("rsp_rdata", {64'd0, rsp_rdata}, {64'd0, e.rdata});
               chk("rsp_err", {95'd0, rsp_err}, {95'd0, e.err});
            end
         end
         if (!mem_cen) chk("idle_mem_zero", {31'd0, mem_wen, mem_addr, mem_wdata}, 96'd0);
         if (mem_cen && stab_en)
            chk("access_stable", {31'd0, mem_wen, mem_addr, mem_wdata},
                {31'd0, stab_wen, stab_addr, stab_wdata});
      end
      if (mem_cen) begin
         if (!prev_cen) begin
            gaps.push_back(zeros);
            run_len = 0;
         end
         run_len++;
      end else begin
         if (prev_cen) begin
            runs.push_back(run_len);
            zeros = 0;
         end
         zeros++;
      end
      prev_cen   = mem_cen;
      prev_valid = rsp_valid && rst_n;
   end

   task automatic send(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] er, input logic ee, input logic push_exp,
                       output int acc_at);
      logic r;
      int   n;
      @(negedge clk);
      req_valid = 1'b1;
      req_wen   = wen;
      req_addr  = addr;
      req_wdata = wdata;
      n = 0;
      acc_at = -1;
      forever begin
         #1;
         r = req_ready;
         @(posedge clk);
         if (r) break;
         n++;
         if (n > 300) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got no accept, required accept of addr %0h", addr);
            return;
         end
         @(negedge clk);
      end
      if (push_exp) exp_q.push_back('{er, ee});
      #1 acc_at = cyc;
   endtask

   task automatic idle_req();
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk(name, exp_q.size(), 96'd0);
      repeat (3) @(negedge clk);
   endtask

   task automatic clear_logs();
      runs.delete();
      gaps.delete();
      rsp_cyc.delete();
   endtask

   initial begin
      int a0, a1, a2, n;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_mem", {31'd0, mem_cen, mem_wen, mem_addr, mem_wdata}, 96'd0);
      chk("rst_rsp", {62'd0, rsp_valid, rsp_err, rsp_rdata}, 96'd0);
      chk("rst_err", {95'd0, err}, 96'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", {95'd0, req_ready}, 96'd1);

      // Read with 10 stall cycles
      clear_logs();
      stall_n = 10; stab_en = 1'b1; stab_wen = 1'b0; stab_addr = 32'h0001_0010; stab_wdata = 32'h0;
      send(1'b0, 32'h0001_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1, a0);
      idle_req();
      drain("read_drain");
      chk("read_nruns", runs.size(), 96'd1);
      if (runs.size() > 0) chk("read_cen_cycles", runs[0], 96'd11);

      // Write with 5 stall cycles
      clear_logs();
      stall_n = 5; stab_wen = 1'b1; stab_addr = 32'h0001_0004; stab_wdata = 32'hCAFE_F00D;
      send(1'b1, 32'h0001_0004, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b1, a0);
      idle_req();
      drain("write_drain");
      chk("write_nruns", runs.size(), 96'd1);
      if (runs.size() > 0) chk("write_cen_cycles", runs[0], 96'd6);

      // Three back-to-back requests
      clear_logs();
      stall_n = 2; stab_en = 1'b0;
      send(1'b0, 32'h0000_0100, 32'h0, 32'h1234_5778, 1'b0, 1'b1, a0);
      send(1'b1, 32'h0000_0104, 32'h1111_1111, 32'h0, 1'b0, 1'b1, a1);
      chk("b2b_ready_fell", {95'd0, req_ready}, 96'd0);
      send(1'b0, 32'h0000_0108, 32'h0, 32'h1234_5770, 1'b0, 1'b1, a2);
      idle_req();
      drain("b2b_drain");
      chk("b2b_second_accept", a1, a0 + 1);
      chk("b2b_nrsp", rsp_cyc.size(), 96'd3);
      if (rsp_cyc.size() > 0) chk("b2b_third_on_completion", a2, rsp_cyc[0]);
      chk("b2b_nruns", runs.size(), 96'd3);
      for (int i = 0; i < runs.size(); i++) chk("b2b_cen_cycles", runs[i], 96'd3);
      for (int i = 1; i < gaps.size(); i++) chk("b2b_gap", gaps[i], 96'd1);

      // Reset three cycles into an access
      stall_n = 1000;
      send(1'b0, 32'h0000_0040, 32'h0, 32'h0, 1'b0, 1'b0, a0);
      idle_req();
      n = 0;
      while (!mem_cen && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("rstmid_access_seen", {95'd0, mem_cen}, 96'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rstmid_mem", {31'd0, mem_cen, mem_wen, mem_addr, mem_wdata}, 96'd0);
      chk("rstmid_rsp", {62'd0, rsp_valid, rsp_err, rsp_rdata}, 96'd0);
      chk("rstmid_err", {95'd0, err}, 96'd0);
      rst_n = 1'b1;
      stall_n = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rstmid_fifo_empty", {94'd0, mem_cen, req_ready}, 96'd1);
      end

`ifdef MEM_INIT_TIMEOUT_EN
      // Stall forever: timeout after 8 access cycles
      clear_logs();
      stall_n = 1000;
      send(1'b0, 32'h0000_0080, 32'h0, 32'h0, 1'b1, 1'b1, a0);
      idle_req();
      drain("tmo_drain");
      chk("tmo_nruns", runs.size(), 96'd1);
      if (runs.size() > 0) chk("tmo_cen_cycles", runs[0], 96'd8);
      chk("tmo_err_set", {95'd0, err}, 96'd1);
      chk("tmo_cen_low", {95'd0, mem_cen}, 96'd0);
      stall_n = 0;
      send(1'b1, 32'h0000_0084, 32'h0000_5555, 32'h0, 1'b0, 1'b1, a0);
      idle_req();
      drain("tmo_after_drain");
      chk("tmo_err_sticky", {95'd0, err}, 96'd1);
      chk("tmo_rsp_err_cleared", {95'd0, rsp_err}, 96'd0);
`else
      // Long stall without timeout support still completes normally
      clear_logs();
      stall_n = 12;
      send(1'b0, 32'h0000_0020, 32'h0, 32'h1234_5658, 1'b0, 1'b1, a0);
      idle_req();
      drain("long_drain");
      chk("long_nruns", runs.size(), 96'd1);
      if (runs.size() > 0) chk("long_cen_cycles", runs[0], 96'd13);
      chk("long_err_zero", {95'd0, err}, 96'd0);
      chk("long_rsp_err_zero", {95'd0, rsp_err}, 96'd0);
`endif

      chk("final_queue_empty", exp_q.size(), 96'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      n_cmp++;
      n_bad++;
      $display("FAIL watchdog: got no completion of the run, required finish before time limit");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
